// File: rtl/dbg_writer_pkg.sv
// Shared definitions for the front-panel debug writer: target-select
// encodings, default memory size and the writer FSM state codes.
package dbg_writer_pkg;

  // Target select encodings driven by the board's select switches
  localparam logic [1:0] SEL_GR   = 2'd0;
  localparam logic [1:0] SEL_MEM  = 2'd1;
  localparam logic [1:0] SEL_PC   = 2'd2;
  localparam logic [1:0] SEL_ADDR = 2'd3;

  // Number of writable data-memory words on this board
  localparam int MEM_SIZE_DEF = 32;

  // Writer FSM states
  typedef enum logic [1:0] {
    DW_IDLE   = 2'd0,
    DW_WR_GR  = 2'd1,
    DW_WR_MEM = 2'd2
  } dw_state_t;

endpackage

// File: rtl/dbg_writer_btn_edge.sv
// Button conditioner: two-flop synchroniser followed by a registered
// rising-edge detector. Produces a single-cycle pulse three clocks after
// the raw button is first sampled high.
module dbg_writer_btn_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  logic sync1;
  logic sync2;
  logic prev;

  // Synchronise the raw button, remember the last level, register the edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
      pulse <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      prev  <= sync2;
      pulse <= sync2 & ~prev;
    end
  end

endmodule

// File: rtl/dbg_writer.sv
// Front-panel debug writer. The operator steps an 8-bit address, stages a
// 16-bit word in two byte halves from the switches, and commits it to a
// general register or data memory over a we/ack handshake with timeout.
module dbg_writer
  import dbg_writer_pkg::*;
#(
  parameter int GR_SIZE  = 8,
  parameter int MEM_SIZE = MEM_SIZE_DEF,
  parameter int TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_step,
  input  logic        dir,
  input  logic        btn_hi,
  input  logic        btn_lo,
  input  logic        btn_commit,
  input  logic [7:0]  sw,
  input  logic [1:0]  select,
  output logic        mem_we,
  output logic [7:0]  mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  output logic        gr_we,
  output logic [2:0]  gr_addr,
  output logic [15:0] gr_wdata,
  input  logic        gr_ack,
  output logic [7:0]  address,
  output logic [15:0] data_buf,
  output logic        busy,
  output logic        error
);

  localparam logic [7:0] GR_LAST  = 8'(GR_SIZE - 1);
  localparam logic [7:0] MEM_LAST = 8'(MEM_SIZE - 1);
  localparam logic [8:0] GR_LIM   = 9'(GR_SIZE);
  localparam logic [8:0] MEM_LIM  = 9'(MEM_SIZE);
  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

  logic step_p;
  logic hi_p;
  logic lo_p;
  logic commit_p;

  dbg_writer_btn_edge u_step   (.clk(clk), .reset(reset), .btn(btn_step),   .pulse(step_p));
  dbg_writer_btn_edge u_hi     (.clk(clk), .reset(reset), .btn(btn_hi),     .pulse(hi_p));
  dbg_writer_btn_edge u_lo     (.clk(clk), .reset(reset), .btn(btn_lo),     .pulse(lo_p));
  dbg_writer_btn_edge u_commit (.clk(clk), .reset(reset), .btn(btn_commit), .pulse(commit_p));

  dw_state_t  state;
  logic [7:0] tcount;
  logic       gr_ok;
  logic       mem_ok;
  logic [7:0] gr_next;
  logic [7:0] mem_next;

  // Range checks and post-increment addresses that wrap at the target size
  assign gr_ok    = ({1'b0, address} < GR_LIM);
  assign mem_ok   = ({1'b0, address} < MEM_LIM);
  assign gr_next  = (address == GR_LAST)  ? 8'd0 : address + 8'd1;
  assign mem_next = (address == MEM_LAST) ? 8'd0 : address + 8'd1;

  // Writer FSM: operator edits in IDLE, one strobe held per commit until ack or timeout
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= DW_IDLE;
      tcount    <= 8'd0;
      address   <= 8'd0;
      data_buf  <= 16'd0;
      busy      <= 1'b0;
      error     <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 8'd0;
      mem_wdata <= 16'd0;
      gr_we     <= 1'b0;
      gr_addr   <= 3'd0;
      gr_wdata  <= 16'd0;
    end else begin
      case (state)
        DW_IDLE: begin
          if (commit_p) begin
            if (select == SEL_GR && gr_ok) begin
              state    <= DW_WR_GR;
              gr_we    <= 1'b1;
              gr_addr  <= address[2:0];
              gr_wdata <= data_buf;
              busy     <= 1'b1;
              error    <= 1'b0;
              tcount   <= 8'd0;
            end else if (select == SEL_MEM && mem_ok) begin
              state     <= DW_WR_MEM;
              mem_we    <= 1'b1;
              mem_addr  <= address;
              mem_wdata <= data_buf;
              busy      <= 1'b1;
              error     <= 1'b0;
              tcount    <= 8'd0;
            end else begin
              error <= 1'b1;
            end
          end else begin
            if (step_p) begin
              address <= dir ? address + 8'd1 : address - 8'd1;
            end
            if (hi_p) begin
              data_buf[15:8] <= sw;
            end
            if (lo_p) begin
              data_buf[7:0] <= sw;
            end
          end
        end
        DW_WR_GR: begin
          if (gr_ack) begin
            state   <= DW_IDLE;
            gr_we   <= 1'b0;
            busy    <= 1'b0;
            address <= gr_next;
          end else if (tcount == TO_LIMIT) begin
            state <= DW_IDLE;
            gr_we <= 1'b0;
            busy  <= 1'b0;
            error <= 1'b1;
          end else begin
            tcount <= tcount + 8'd1;
          end
        end
        DW_WR_MEM: begin
          if (mem_ack) begin
            state   <= DW_IDLE;
            mem_we  <= 1'b0;
            busy    <= 1'b0;
            address <= mem_next;
          end else if (tcount == TO_LIMIT) begin
            state  <= DW_IDLE;
            mem_we <= 1'b0;
            busy   <= 1'b0;
            error  <= 1'b1;
          end else begin
            tcount <= tcount + 8'd1;
          end
        end
        default: begin
          state  <= DW_IDLE;
          gr_we  <= 1'b0;
          mem_we <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dbg_writer.sv
// Testbench for dbg_writer: directed front-panel sequences followed by
// randomized operator activity, all checked against a simple model of
// address, staged word, error flag and strobe timing.
module tb_dbg_writer;
  import dbg_writer_pkg::*;

  localparam int GRN  = 8;
  localparam int MEMN = MEM_SIZE_DEF;
  localparam int TO   = 15;

  logic        clk;
  logic        reset;
  logic        btn_step;
  logic        dir;
  logic        btn_hi;
  logic        btn_lo;
  logic        btn_commit;
  logic [7:0]  sw;
  logic [1:0]  select;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic        gr_we;
  logic [2:0]  gr_addr;
  logic [15:0] gr_wdata;
  logic        gr_ack;
  logic [7:0]  address;
  logic [15:0] data_buf;
  logic        busy;
  logic        error;

  int total = 0;
  int bad   = 0;

  logic [7:0]  m_addr;
  logic [15:0] m_data;
  logic        m_err;

  dbg_writer #(.GR_SIZE(GRN), .MEM_SIZE(MEMN), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .btn_step(btn_step), .dir(dir),
    .btn_hi(btn_hi), .btn_lo(btn_lo), .btn_commit(btn_commit), .sw(sw),
    .select(select), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .gr_we(gr_we),
    .gr_addr(gr_addr), .gr_wdata(gr_wdata), .gr_ack(gr_ack),
    .address(address), .data_buf(data_buf), .busy(busy), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkState(input string tag);
    checkOutput({tag, ".address"}, 32'(address), 32'(m_addr));
    checkOutput({tag, ".data_buf"}, 32'(data_buf), 32'(m_data));
    checkOutput({tag, ".error"}, 32'(error), 32'(m_err));
  endtask

  // Press and release a set of buttons together, long enough for one pulse
  task automatic applyStimulus(input bit s, input bit h, input bit l);
    btn_step = s;
    btn_hi   = h;
    btn_lo   = l;
    repeat (5) tick();
    btn_step = 1'b0;
    btn_hi   = 1'b0;
    btn_lo   = 1'b0;
    repeat (3) tick();
  endtask

  task automatic doStep(input bit d);
    dir = d;
    applyStimulus(1'b1, 1'b0, 1'b0);
    m_addr = d ? m_addr + 8'd1 : m_addr - 8'd1;
  endtask

  task automatic doLoad(input bit h, input bit l, input logic [7:0] v);
    sw = v;
    applyStimulus(1'b0, h, l);
    if (h) m_data[15:8] = v;
    if (l) m_data[7:0] = v;
  endtask

  // ackDelay < 0 means never acknowledge
  task automatic doCommit(input logic [1:0] sel, input int ackDelay,
                          input bit busyPoke, input bit resetMid);
    bit valid;
    bit is_gr;
    bit seen;
    bit both;
    int cnt;
    int size;
    logic [7:0] a;
    a      = m_addr;
    is_gr  = (sel == SEL_GR);
    valid  = (sel == SEL_GR && int'(m_addr) < GRN) || (sel == SEL_MEM && int'(m_addr) < MEMN);
    size   = is_gr ? GRN : MEMN;
    select = sel;
    btn_commit = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (gr_we || mem_we) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("strobe_seen", 32'(seen), 32'(valid));
    if (seen && valid) begin
      if (is_gr) begin
        checkOutput("gr_we", 32'(gr_we), 32'd1);
        checkOutput("gr_addr", 32'(gr_addr), 32'(a[2:0]));
        checkOutput("gr_wdata", 32'(gr_wdata), 32'(m_data));
        mem_ack = 1'b1;
      end else begin
        checkOutput("mem_we", 32'(mem_we), 32'd1);
        checkOutput("mem_addr", 32'(mem_addr), 32'(a));
        checkOutput("mem_wdata", 32'(mem_wdata), 32'(m_data));
        gr_ack = 1'b1;
      end
      checkOutput("busy_in_write", 32'(busy), 32'd1);
      cnt  = 1;
      both = 1'b0;
      forever begin
        if (ackDelay >= 0 && cnt == ackDelay + 1) begin
          if (is_gr) gr_ack = 1'b1; else mem_ack = 1'b1;
        end
        if (busyPoke && cnt == 1) begin
          sw = ~sw;
          dir = $urandom_range(0, 1);
          btn_step = 1'b1; btn_hi = 1'b1; btn_lo = 1'b1;
        end
        if (busyPoke && cnt == 7) begin
          btn_step = 1'b0; btn_hi = 1'b0; btn_lo = 1'b0;
        end
        if (resetMid && cnt == 3) begin
          reset = 1'b1;
          #1;
          checkOutput("reset_mem_we", 32'(mem_we), 32'd0);
          checkOutput("reset_gr_we", 32'(gr_we), 32'd0);
          checkOutput("reset_address", 32'(address), 32'd0);
          checkOutput("reset_busy", 32'(busy), 32'd0);
          m_addr = 8'd0; m_data = 16'd0; m_err = 1'b0;
          break;
        end
        tick();
        if (gr_we && mem_we) both = 1'b1;
        if (!(gr_we || mem_we)) break;
        cnt++;
        if (cnt > 40) break;
      end
      gr_ack  = 1'b0;
      mem_ack = 1'b0;
      if (!resetMid) begin
        checkOutput("no_dual_strobe", 32'(both), 32'd0);
        checkOutput("strobe_cycles", 32'(cnt), (ackDelay >= 0) ? 32'(ackDelay + 1) : 32'(TO + 1));
        checkOutput("busy_after", 32'(busy), 32'd0);
        if (ackDelay >= 0) begin
          m_addr = (int'(m_addr) + 1 >= size) ? 8'd0 : m_addr + 8'd1;
          m_err  = 1'b0;
        end else begin
          m_err = 1'b1;
        end
      end
    end else if (!valid) begin
      m_err = 1'b1;
    end
    btn_commit = 1'b0;
    repeat (3) tick();
    if (resetMid) begin
      reset = 1'b0;
      tick();
    end
  endtask

  initial begin
    reset = 1'b1;
    btn_step = 1'b0; btn_hi = 1'b0; btn_lo = 1'b0; btn_commit = 1'b0;
    dir = 1'b1; sw = 8'd0; select = SEL_GR; mem_ack = 1'b0; gr_ack = 1'b0;
    m_addr = 8'd0; m_data = 16'd0; m_err = 1'b0;
    repeat (3) tick();
    checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
    checkOutput("rst_gr_we", 32'(gr_we), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("rst_gr_wdata", 32'(gr_wdata), 32'd0);
    checkState("rst");
    reset = 1'b0;
    tick();

    doStep(1'b1); doStep(1'b1); doStep(1'b1); doStep(1'b0);
    checkState("step_to_2");
    doStep(1'b0); doStep(1'b0); doStep(1'b0);
    checkState("step_wrap_ff");

    for (int i = 0; i < 6; i++) doStep(1'b1);
    doLoad(1'b1, 1'b0, 8'hAB);
    doLoad(1'b0, 1'b1, 8'hCD);
    checkState("staged_abcd");
    doCommit(SEL_MEM, 2, 1'b0, 1'b0);
    checkState("mem_write_5");

    doStep(1'b1);
    doLoad(1'b1, 1'b1, 8'h12);
    doLoad(1'b0, 1'b1, 8'h34);
    checkState("staged_1234");
    doCommit(SEL_GR, 0, 1'b0, 1'b0);
    checkState("gr_write_wrap");

    for (int i = 0; i < 8; i++) doStep(1'b1);
    doCommit(SEL_GR, 0, 1'b0, 1'b0);
    checkState("gr_reject_8");
    doStep(1'b0);
    doCommit(SEL_MEM, 1, 1'b0, 1'b0);
    checkState("valid_clears_error");

    doCommit(SEL_MEM, -1, 1'b1, 1'b0);
    checkState("timeout_busy_poke");
    doCommit(SEL_PC, 0, 1'b0, 1'b0);
    checkState("pc_reject");
    doCommit(SEL_ADDR, 0, 1'b0, 1'b0);
    checkState("addr_reject");

    doCommit(SEL_MEM, -1, 1'b0, 1'b1);
    checkState("reset_mid_write");

    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 3))
        0: doStep(1'($urandom_range(0, 1)));
        1: begin
          bit h;
          bit l;
          h = 1'($urandom_range(0, 1));
          l = h ? 1'($urandom_range(0, 1)) : 1'b1;
          doLoad(h, l, 8'($urandom_range(0, 255)));
        end
        default: begin
          int d;
          d = $urandom_range(0, 5);
          doCommit(2'($urandom_range(0, 3)), (d == 5) ? -1 : d, 1'b0, 1'b0);
        end
      endcase
      checkState("random_op");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dbg_writer.md
Name: dbg_writer

Overview:
- Front-panel debug writer: the write-side counterpart of the board's display pointer, which only reads GR/MEM for display.
- Operator steps an 8-bit address with buttons and enters a 16-bit word from 8 switches in two halves. A commit button then writes the word into a general register or data memory over a we/ack handshake.
- Sits between the board I/O and the CPU's GR file / memory debug write ports. Only used while the CPU is halted.

Parameters:
- GR_SIZE, 8, number of general registers; GR write port address is 3 bits.
- MEM_SIZE, `MEM_SIZE (from define.v), number of writable memory words.
- TIMEOUT, 15, cycles to wait for ack before aborting a write (1..255).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- btn_step  in  1  raw button: step address
- dir  in  1  step direction: 1 = +1, 0 = -1
- btn_hi  in  1  raw button: load sw into data_buf[15:8]
- btn_lo  in  1  raw button: load sw into data_buf[7:0]
- btn_commit  in  1  raw button: write data_buf at address
- sw  in  8  data switches
- select  in  2  target: `GR, `MEM, `PC, `ADDR (define.v encodings)
- mem_we  out  1  memory write strobe
- mem_addr  out  8  memory write address
- mem_wdata  out  16  memory write data
- mem_ack  in  1  memory write accepted
- gr_we  out  1  GR write strobe
- gr_addr  out  3  GR index
- gr_wdata  out  16  GR write data
- gr_ack  in  1  GR write accepted
- address  out  8  current pointer, for display
- data_buf  out  16  staged word, for display
- busy  out  1  write in flight
- error  out  1  sticky: last commit rejected or timed out

Behaviour:
- Reset (async, active-high) forces:
  - all outputs to 0;
  - FSM to IDLE;
  - timeout counter and synchroniser flops to 0.
- Reset mid-write drops mem_we/gr_we immediately.
- Button inputs:
  - Each raw button passes through a 2-flop synchroniser, then a rising-edge detector, giving a 1-cycle pulse.
  - Latency from the button's first sampled high to the pulse is 3 clk.
- FSM states:
  - IDLE: accepts step, hi/lo loads and commit.
  - WR_GR: holds gr_we.
  - WR_MEM: holds mem_we.
- Step (IDLE only): address <= address ± 1 according to dir, wrapping modulo 256 (0xFF+1 = 0x00, 0x00-1 = 0xFF). Ignored while busy.
- Hi/lo load (IDLE only): a loaded byte is visible on data_buf the next cycle. Both pulses in the same cycle load both halves with sw. Ignored while busy.
- Commit pulse in IDLE:
  - select == `GR and address < GR_SIZE: go to WR_GR, error <= 0.
  - select == `MEM and address < MEM_SIZE: go to WR_MEM, error <= 0.
  - Any other case, including `PC or `ADDR: stay in IDLE, error <= 1, no strobe issued.
- Commit and step in the same cycle: commit wins and the step is dropped. Loads in the same cycle as commit are dropped.
- WR_x, entered the cycle after the commit pulse:
  - we = 1 and busy = 1.
  - addr is address (gr_addr = address[2:0]); wdata is data_buf. Both are held stable until the write ends.
  - Timeout counter starts at 0 and increments each cycle.
- Ack seen high while in WR_x:
  - next cycle: we = 0, busy = 0, state IDLE;
  - address post-increments by 1, wrapping to 0 when it reaches the target size (GR_SIZE or MEM_SIZE).
- Ack is ignored outside WR_x. Only the ack matching the active target counts.
- Timeout: if the counter reaches TIMEOUT without ack, then next cycle we = 0, error <= 1, state IDLE, address unchanged.
- mem_we and gr_we are never both high. Each strobe lasts at least 1 cycle. Back-to-back writes need a fresh commit edge.

Decomposition:
- define.v (shared) holds `GR, `MEM, `PC, `ADDR, `MEM_SIZE, plus new state codes `DW_IDLE, `DW_WR_GR, `DW_WR_MEM.
- One sub-module, btn_edge (2-flop synchroniser plus rising-edge pulse, async reset), instantiated 4 times.

Test Plan:
- Reset then 3 step presses with dir=1, then 1 with dir=0 -> address = 0x02. Step with dir=0 from 0x00 -> 0xFF.
- sw=0xAB + hi, sw=0xCD + lo, select=`MEM, address=0x05, commit, mem_ack returned after 2 cycles:
  - mem_we held 3 cycles with mem_addr=0x05, mem_wdata=0xABCD;
  - then address = 0x06 and error = 0.
- select=`GR, address=7, data_buf=0x1234, commit, gr_ack immediately -> gr_addr=7, gr_wdata=0x1234, address wraps to 0.
- select=`GR, address=8, commit -> no strobe, error=1. Next valid commit clears error.
- select=`MEM, commit, ack never returned -> mem_we drops after TIMEOUT cycles, error=1, address unchanged.
- During busy, pulse step/hi/lo -> address and data_buf unchanged. Assert reset mid-write -> mem_we=0 asynchronously, address=0.
